mul_div_unit: RTL and testbench

//  Multi-cycle unsigned multiply/divide engine beside the single-cycle ALU in the CPU32

---
 rtl/mul_div_unit_pkg.sv | 28 ++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared types for the CPU32 multiply/divide engine.
//   - mdu_op_e    : op encoding shared with the instruction decoder
//   - mdu_state_e : engine sequencing states
//   - mdu_is_div  : true for the divide family (DIVU/REMU)
package mul_div_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  // Divide ops share bit 1 of the encoding.
  function automatic logic mdu_is_div(input mdu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Issue/result bundle between execute-stage control and the multiply/divide engine.
//   start, op, left, right : request from control (master)
//   busy, done, out        : status and result from the engine (slave)
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic        start;
  mdu_op_e     op;
  logic [31:0] left;
  logic [31:0] right;
  logic        busy;
  logic        done;
  logic [31:0] out;

  modport master (
    output start, op, left, right,
    input  busy, done, out
  );

  modport slave (
    input  start, op, left, right,
    output busy, done, out
  );

endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Radix-2 unsigned multiply/divide engine, one result bit per clock, fixed latency
//   of ITERS iterations after the accept edge for every op and operand value.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, discards any op in flight
//   bus   : mul_div_unit_if.slave (start/op/left/right in, busy/done/out back)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | iterating, busy=1, start ignored
// DONE  | one-cycle done strobe; a start here is accepted back-to-back
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int ITERS = MDU_WIDTH
) (
  input logic             clk,
  input logic             reset,
  mul_div_unit_if.slave   bus
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(ITERS - 1);

  mdu_state_e     state;
  mdu_op_e        op_r;
  logic [CW-1:0]  count;
  logic [32:0]    acc_hi;   // MUL: high product half + carry slot; DIV: partial remainder
  logic [31:0]    acc_lo;   // MUL: low product / multiplier bits; DIV: dividend in, quotient out
  logic [31:0]    divisor;  // right operand for both families
  logic [31:0]    out_r;

  logic           div_mode;
  logic [32:0]    rem_sh;
  logic [32:0]    add_a;
  logic [32:0]    add_b;
  logic           add_cin;
  logic [33:0]    add_sum;
  logic           rem_ge;
  logic [32:0]    hi_nx;
  logic [31:0]    lo_nx;
  logic [31:0]    result;

  assign div_mode = mdu_is_div(op_r);
  assign rem_sh   = {acc_hi[31:0], acc_lo[31]};

  // Single 33-bit adder shared by both families. For divide it computes
  // rem_sh - divisor as rem_sh + ~divisor + 1; the carry out of bit 33 is then
  // the "no borrow" flag, i.e. rem_sh >= divisor.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (div_mode) begin
      add_a   = rem_sh;
      add_b   = ~{1'b0, divisor};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_hi[31:0]};
      add_b   = acc_lo[0] ? {1'b0, divisor} : 33'd0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};
  end

  always_comb begin
    rem_ge = 1'b0;
    hi_nx  = '0;
    lo_nx  = '0;
    if (div_mode) begin
      rem_ge = add_sum[33];
      hi_nx  = rem_ge ? add_sum[32:0] : rem_sh;
      lo_nx  = {acc_lo[30:0], rem_ge};
    end else begin
      // Shift {carry, hi, lo} right by one.
      hi_nx  = {1'b0, add_sum[32:1]};
      lo_nx  = {add_sum[0], acc_lo[31:1]};
    end
  end

  always_comb begin
    result = '0;
    unique case (op_r)
      MDU_MUL:   result = lo_nx;
      MDU_MULHU: result = hi_nx[31:0];
      MDU_DIVU:  result = lo_nx;
      MDU_REMU:  result = hi_nx[31:0];
      default:   result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_r    <= MDU_MUL;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      divisor <= '0;
      out_r   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            op_r    <= bus.op;
            count   <= COUNT_LOAD;
            acc_hi  <= '0;
            acc_lo  <= bus.left;
            divisor <= bus.right;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          if (count == '0) begin
            out_r <= result;
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.out  = out_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed vectors with hand-computed results for mul_div_unit: latency, busy
//   width, done width, result hold, divide by zero, ignored starts, back-to-back
//   issue and asynchronous reset mid-operation.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit #(.ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at the falling edge; returns 1ns after the accept edge.
  task automatic issue(input mdu_op_e o, input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.left  = l;
    bus.right = r;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called 1ns after the accept edge. Counts edges until done, busy samples,
  // and whether out moved before done. p1/p2 > 0 pulse a foreign start
  // (MUL 9x9) on that cycle; with p1 == 0 start is left untouched.
  task automatic wait_done(input int p1, input int p2,
                           output int edges, output int busy_n, output bit out_moved);
    logic [31:0] out0;
    out0      = bus.out;
    edges     = 0;
    busy_n    = bus.busy ? 1 : 0;
    out_moved = 1'b0;
    while (!bus.done && edges < 100) begin
      if (p1 > 0) begin
        if (edges == p1 - 1 || edges == p2 - 1) begin
          bus.start = 1'b1;
          bus.op    = MDU_MUL;
          bus.left  = 32'd9;
          bus.right = 32'd9;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_n++;
      if (!bus.done && bus.out !== out0) out_moved = 1'b1;
    end
    if (p1 > 0) bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input mdu_op_e o, input logic [31:0] l,
                        input logic [31:0] r, input logic [31:0] exp,
                        input int p1 = 0, input int p2 = 0);
    int e;
    int b;
    bit m;
    issue(o, l, r);
    check({tag, "_busy_at_accept"}, 32'(bus.busy), 32'd1);
    wait_done(p1, p2, e, b, m);
    check({tag, "_latency"}, 32'(e), 32'd32);
    check({tag, "_busy_cycles"}, 32'(b), 32'd32);
    check({tag, "_out"}, bus.out, exp);
    check({tag, "_out_stable_before_done"}, 32'(m), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
    check({tag, "_out_hold"}, bus.out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int e;
    int b;
    bit m;
    int dn;

    bus.start = 1'b0;
    bus.op    = MDU_MUL;
    bus.left  = '0;
    bus.right = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_out", bus.out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul_7x6",    MDU_MUL,   32'd7,          32'd6,          32'd42);
    run_op("mulhu_max",  MDU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run_op("mul_max",    MDU_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
    run_op("mulhu_big",  MDU_MULHU, 32'h8000_0000,  32'd6,          32'd3);
    run_op("divu_100_7", MDU_DIVU,  32'd100,        32'd7,          32'd14);
    run_op("remu_100_7", MDU_REMU,  32'd100,        32'd7,          32'd2);
    run_op("divu_by0",   MDU_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF);
    run_op("remu_by0",   MDU_REMU,  32'd5,          32'd0,          32'd5);
    run_op("divu_max_1", MDU_DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
    run_op("divu_ignore_start", MDU_DIVU, 32'd100, 32'd7, 32'd14, 5, 20);

    // Back-to-back: start held high through RUN and into DONE.
    issue(MDU_MUL, 32'd5, 32'd5);
    bus.start = 1'b1;
    bus.op    = MDU_MUL;
    bus.left  = 32'd3;
    bus.right = 32'd3;
    wait_done(0, 0, e, b, m);
    check("b2b_first_latency", 32'(e), 32'd32);
    check("b2b_first_out", bus.out, 32'd25);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_second_accept_busy", 32'(bus.busy), 32'd1);
    check("b2b_second_accept_done", 32'(bus.done), 32'd0);
    check("b2b_first_out_held", bus.out, 32'd25);
    wait_done(0, 0, e, b, m);
    check("b2b_second_latency", 32'(e), 32'd32);
    check("b2b_second_out", bus.out, 32'd9);
    check("b2b_out_held_between", 32'(m), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_done_width", 32'(bus.done), 32'd0);

    // Asynchronous reset ten cycles into an operation.
    issue(MDU_MUL, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    check("async_reset_done", 32'(bus.done), 32'd0);
    check("async_reset_out", bus.out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    run_op("mul_2x2_after_reset", MDU_MUL, 32'd2, 32'd2, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
